// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data, memory, stall and counter signals of the unified-memory arbiter
// slave modport: arbiter side; master modport: pipeline/memory side
interface mem_port_arbiter_if #(
  parameter int WORD_SIZE = 16
);
  logic                 i_req, i_flush, i_ready;
  logic [WORD_SIZE-1:0] i_address, i_rdata;
  logic                 d_readM, d_writeM, d_ready;
  logic [WORD_SIZE-1:0] d_address, d_wdata, d_rdata;
  logic                 m_readM, m_writeM;
  logic [WORD_SIZE-1:0] m_address, m_wdata, m_rdata;
  logic                 stall_IF, stall_MEM;
  logic [WORD_SIZE-1:0] num_i_access, num_d_access, num_conflict;
  modport slave (
    input  i_req, i_address, i_flush, d_readM, d_writeM, d_address, d_wdata, m_rdata,
    output i_rdata, i_ready, d_rdata, d_ready, m_readM, m_writeM, m_address, m_wdata,
    output stall_IF, stall_MEM, num_i_access, num_d_access, num_conflict
  );
  modport master (
    output i_req, i_address, i_flush, d_readM, d_writeM, d_address, d_wdata, m_rdata,
    input  i_rdata, i_ready, d_rdata, d_ready, m_readM, m_writeM, m_address, m_wdata,
    input  stall_IF, stall_MEM, num_i_access, num_d_access, num_conflict
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between IF fetches and MEM data accesses, data first
// ports: clk, reset_n (async active-low), bus (mem_port_arbiter_if.slave: fetch, data, memory, stalls, counters)
// ARB_PERF_COUNT_EN enables the num_i_access / num_d_access / num_conflict counters; otherwise they read 0
module mem_port_arbiter #(
  parameter int WORD_SIZE   = 16,
  parameter int MEM_LATENCY = 2
) (
  input logic               clk,
  input logic               reset_n,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, I_ACC, D_ACC} state_t;
  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);
  state_t               state, state_nx;
  logic [3:0]           cnt, cnt_nx;
  logic [WORD_SIZE-1:0] addr, addr_nx, wdata, wdata_nx;
  logic                 is_write, is_write_nx, discard, discard_nx;
  logic                 d_req, acc, done, grant_d, grant_i;
  assign d_req = bus.d_readM | bus.d_writeM;
  assign acc   = state != IDLE;
  assign done  = acc && cnt == 4'd0;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      addr     <= '0;
      wdata    <= '0;
      is_write <= 1'b0;
      discard  <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      addr     <= addr_nx;
      wdata    <= wdata_nx;
      is_write <= is_write_nx;
      discard  <= discard_nx;
    end
  // at completion only the other requester may be granted; the one just served waits a cycle
  always_comb begin
    grant_d     = d_req && (state == IDLE || (state == I_ACC && done));
    grant_i     = bus.i_req && !grant_d && (state == IDLE || (state == D_ACC && done));
    state_nx    = grant_d ? D_ACC : grant_i ? I_ACC : done ? IDLE : state;
    cnt_nx      = (grant_d || grant_i) ? CNT_INIT : cnt != 4'd0 ? cnt - 4'd1 : cnt;
    addr_nx     = grant_d ? bus.d_address : grant_i ? bus.i_address : addr;
    wdata_nx    = grant_d ? bus.d_wdata : wdata;
    is_write_nx = grant_d ? bus.d_writeM : grant_i ? 1'b0 : is_write;
    discard_nx  = (grant_d || grant_i) ? 1'b0 : (state == I_ACC && bus.i_flush) ? 1'b1 : discard;
  end
  assign bus.m_readM   = acc && !is_write;
  assign bus.m_writeM  = state == D_ACC && is_write;
  assign bus.m_address = acc ? addr : '0;
  assign bus.m_wdata   = state == D_ACC ? wdata : '0;
  // a flushed fetch still runs to completion on the memory but never reports ready
  assign bus.i_ready   = state == I_ACC && done && !discard && !bus.i_flush;
  assign bus.d_ready   = state == D_ACC && done;
  assign bus.i_rdata   = bus.i_ready ? bus.m_rdata : '0;
  assign bus.d_rdata   = bus.d_ready ? bus.m_rdata : '0;
  assign bus.stall_IF  = bus.i_req && !bus.i_ready;
  assign bus.stall_MEM = d_req && !bus.d_ready;
`ifdef ARB_PERF_COUNT_EN
  logic [WORD_SIZE-1:0] n_i, n_d, n_c;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      n_i <= '0;
      n_d <= '0;
      n_c <= '0;
    end else begin
      if (state == I_ACC && done) n_i <= n_i + 1'b1;
      if (state == D_ACC && done) n_d <= n_d + 1'b1;
      if (bus.i_req && state != I_ACC && d_req) n_c <= n_c + 1'b1;
    end
  assign bus.num_i_access = n_i;
  assign bus.num_d_access = n_d;
  assign bus.num_conflict = n_c;
`else
  assign bus.num_i_access = '0;
  assign bus.num_d_access = '0;
  assign bus.num_conflict = '0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized and directed traffic checked by a reservation-based port model and scoreboard
module tb_mem_port_arbiter;
  localparam int W = 16;
  localparam int L = 2;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  mem_port_arbiter_if #(.WORD_SIZE(W)) bus ();
  mem_port_arbiter_if #(.WORD_SIZE(W)) bus1 ();
  mem_port_arbiter #(.WORD_SIZE(W), .MEM_LATENCY(L)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  mem_port_arbiter #(.WORD_SIZE(W), .MEM_LATENCY(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));
  typedef struct {
    bit          kind;
    bit          write;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] data;
    int          start;
    int          done;
    bit          discard;
  } acc_t;
  acc_t        q[$];
  acc_t        cur;
  bit          cur_v = 0, just = 0, last_kind = 0, d_pend;
  logic [15:0] mem     [0:1023];
  logic [15:0] ref_mem [0:1023];
  logic [15:0] n_i = '0, n_d = '0, n_c = '0;
  int          cyc = 0, checks = 0, failures = 0, wcnt = 0;
  assign bus.m_rdata  = mem[bus.m_address[9:0]];
  assign bus1.m_rdata = bus1.m_address ^ 16'hA5A5;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, got, want);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_ready(input bit kind);
    int n = 0;
    do begin
      tick;
      n++;
    end while (!(kind ? bus.d_ready : bus.i_ready) && n < 60);
    if (!(kind ? bus.d_ready : bus.i_ready)) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout kind=%0d got=none want=ready within 60 cycles", kind);
    end
    tick;
  endtask
  task automatic fetch_req(input logic [15:0] a);
    bus.i_req = 1'b1;
    bus.i_address = a;
    wait_ready(1'b0);
    bus.i_req = 1'b0;
  endtask
  task automatic data_req(input bit w, input logic [15:0] a, input logic [15:0] d);
    bus.d_readM = !w;
    bus.d_writeM = w;
    bus.d_address = a;
    bus.d_wdata = d;
    wait_ready(1'b1);
    bus.d_readM = 1'b0;
    bus.d_writeM = 1'b0;
  endtask
  // memory: writes commit after the strobe has been held L cycles
  initial forever begin
    @(negedge clk);
    if (bus.m_writeM) begin
      if (wcnt + 1 == L) begin
        mem[bus.m_address[9:0]] = bus.m_wdata;
        wcnt = 0;
      end else wcnt++;
    end else wcnt = 0;
  end
  // reference: the port is reserved for L cycles after each grant; data wins, the requester just served sits out one cycle
  initial forever begin
    @(posedge clk);
    if (!reset_n) begin
      q.delete();
      cur_v = 0;
      just = 0;
      n_i = '0;
      n_d = '0;
      n_c = '0;
    end else begin
      d_pend = bus.d_readM || bus.d_writeM;
      if (bus.i_req && d_pend && !(cur_v && !cur.kind && cyc >= cur.start)) n_c = n_c + 1'b1;
      if (cur_v && !cur.kind && cyc >= cur.start && cyc < cur.done && bus.i_flush && q.size() > 0) q[0].discard = 1;
      just = 0;
      if (cur_v && cyc == cur.done) begin
        if (cur.write) ref_mem[cur.addr[9:0]] = cur.wdata;
        if (cur.kind) n_d = n_d + 1'b1;
        else n_i = n_i + 1'b1;
        last_kind = cur.kind;
        just = 1;
        cur_v = 0;
      end
      if (!cur_v && ((d_pend && !(just && last_kind)) || (bus.i_req && !(just && !last_kind)))) begin
        cur.kind = d_pend && !(just && last_kind);
        cur.write = cur.kind && bus.d_writeM;
        cur.addr = cur.kind ? bus.d_address : bus.i_address;
        cur.wdata = bus.d_wdata;
        cur.data = ref_mem[cur.addr[9:0]];
        cur.start = cyc + 1;
        cur.done = cyc + L;
        cur.discard = 0;
        cur_v = 1;
        q.push_back(cur);
      end
    end
    cyc++;
  end
  // monitor: compares every cycle against the head of the scoreboard
  initial forever begin
    bit busy, dn, ei, ed;
    @(negedge clk);
    if (!reset_n) begin
      chk("rst_m_readM", bus.m_readM, 0);
      chk("rst_m_writeM", bus.m_writeM, 0);
      chk("rst_m_address", bus.m_address, 0);
      chk("rst_m_wdata", bus.m_wdata, 0);
      chk("rst_i_ready", bus.i_ready, 0);
      chk("rst_d_ready", bus.d_ready, 0);
      chk("rst_i_rdata", bus.i_rdata, 0);
      chk("rst_d_rdata", bus.d_rdata, 0);
      chk("rst_stall_IF", bus.stall_IF, bus.i_req);
      chk("rst_counters", {bus.num_i_access, bus.num_d_access, bus.num_conflict} == 0, 1);
    end else begin
      busy = q.size() > 0 && cyc >= q[0].start;
      dn = 0;
      ei = 0;
      ed = 0;
      if (busy) begin
        dn = q[0].done == cyc;
        ei = dn && !q[0].kind && !q[0].discard && !bus.i_flush;
        ed = dn && q[0].kind;
        chk("m_readM", bus.m_readM, !q[0].write);
        chk("m_writeM", bus.m_writeM, q[0].write);
        chk("m_address", bus.m_address, q[0].addr);
        if (q[0].write) chk("m_wdata", bus.m_wdata, q[0].wdata);
        if (ei) chk("i_rdata", bus.i_rdata, q[0].data);
        if (ed && !q[0].write) chk("d_rdata", bus.d_rdata, q[0].data);
      end else begin
        chk("idle_m_readM", bus.m_readM, 0);
        chk("idle_m_writeM", bus.m_writeM, 0);
      end
      chk("i_ready", bus.i_ready, ei);
      chk("d_ready", bus.d_ready, ed);
      chk("stall_IF", bus.stall_IF, bus.i_req && !ei);
      chk("stall_MEM", bus.stall_MEM, (bus.d_readM || bus.d_writeM) && !ed);
`ifdef ARB_PERF_COUNT_EN
      chk("num_i_access", bus.num_i_access, n_i);
      chk("num_d_access", bus.num_d_access, n_d);
      chk("num_conflict", bus.num_conflict, n_c);
`else
      chk("counters_off", {bus.num_i_access, bus.num_d_access, bus.num_conflict} == 0, 1);
`endif
      if (dn) void'(q.pop_front());
    end
  end
  initial begin
    logic [15:0] old;
    int bad;
    {bus.i_req, bus.i_flush, bus.d_readM, bus.d_writeM} = '0;
    {bus.i_address, bus.d_address, bus.d_wdata} = '0;
    {bus1.i_req, bus1.i_flush, bus1.d_readM, bus1.d_writeM} = '0;
    {bus1.i_address, bus1.d_address, bus1.d_wdata} = '0;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 16'($urandom);
      ref_mem[i] = mem[i];
    end
    repeat (3) tick;
    reset_n = 1'b1;
    tick;
    fork
      repeat (40) begin
        repeat ($urandom_range(1, 4)) tick;
        fetch_req(16'($urandom));
      end
      repeat (40) begin
        repeat ($urandom_range(1, 4)) tick;
        data_req(1'($urandom), 16'($urandom), 16'($urandom));
      end
    join
    repeat (3) tick;
    fetch_req(16'h0010);
    repeat (2) tick;
    fork
      fetch_req(16'h0020);
      data_req(1'b0, 16'h0100, 16'h0000);
    join
    repeat (2) tick;
    bus.d_writeM = 1'b1;
    bus.d_address = 16'h0200;
    bus.d_wdata = 16'hBEEF;
    tick;
    bus.d_wdata = 16'h0000;
    wait_ready(1'b1);
    bus.d_writeM = 1'b0;
    repeat (2) tick;
    chk("store_mem", mem[10'h200], 16'hBEEF);
    bus.i_req = 1'b1;
    bus.i_address = 16'h0030;
    tick;
    bus.i_flush = 1'b1;
    tick;
    bus.i_flush = 1'b0;
    tick;
    bus.i_address = 16'h0040;
    wait_ready(1'b0);
    bus.i_req = 1'b0;
    repeat (2) tick;
    old = mem[10'h300];
    bus.d_writeM = 1'b1;
    bus.d_address = 16'h0300;
    bus.d_wdata = ~old;
    tick;
    #2;
    reset_n = 1'b0;
    bus.d_writeM = 1'b0;
    #1;
    chk("async_rst_m_writeM", bus.m_writeM, 0);
    chk("async_rst_d_ready", bus.d_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    #4;
    chk("post_rst_outputs", {bus.m_readM, bus.m_writeM, bus.m_address, bus.m_wdata, bus.i_ready, bus.d_ready, bus.i_rdata, bus.d_rdata} == 0, 1);
    chk("lost_write", mem[10'h300], old);
    tick;
    bus1.i_req = 1'b1;
    bus1.i_address = 16'h0040;
    #4;
    chk("l1_c0_i_ready", bus1.i_ready, 0);
    chk("l1_c0_stall_IF", bus1.stall_IF, 1);
    tick;
    #4;
    chk("l1_c1_i_ready", bus1.i_ready, 1);
    chk("l1_c1_i_rdata", bus1.i_rdata, 16'h0040 ^ 16'hA5A5);
    chk("l1_c1_m_readM", bus1.m_readM, 1);
    chk("l1_c1_stall_IF", bus1.stall_IF, 0);
    tick;
    bus1.i_req = 1'b0;
    bus1.d_writeM = 1'b1;
    bus1.d_address = 16'h0055;
    bus1.d_wdata = 16'h1357;
    #4;
    chk("l1_idle_m_readM", bus1.m_readM, 0);
    chk("l1_s0_stall_MEM", bus1.stall_MEM, 1);
    tick;
    #4;
    chk("l1_s1_d_ready", bus1.d_ready, 1);
    chk("l1_s1_m_writeM", bus1.m_writeM, 1);
    chk("l1_s1_m_wdata", bus1.m_wdata, 16'h1357);
    chk("l1_s1_m_address", bus1.m_address, 16'h0055);
    tick;
    bus1.d_writeM = 1'b0;
    repeat (3) tick;
    bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("mem_final_mismatches", bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
